// File: rtl/lane_rx_pkg.sv
// Shared marker defaults, state encoding and tag layout for the lane deskew receiver.
package lane_rx_pkg;

  localparam logic [23:0] FRAME0_DEFAULT    = 24'hAA8D55;
  localparam logic [23:0] FRAME1_DEFAULT    = 24'hAAB155;
  localparam logic [11:0] LINE_MARK_DEFAULT = 12'h555;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_GATHER  = 2'd1;
  localparam logic [1:0] ST_ALIGNED = 2'd2;

  localparam int TAG_W = 3;

  typedef struct packed {
    logic frm;
    logic odd;
    logic line;
  } tag_t;

endpackage

// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew FIFO: synchronous, combinational read port, flush clears both pointers.
module lane_deskew_fifo #(
  parameter int ENTRY_W = 9,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               do_wr;
  logic               do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a write when the same cycle pops the oldest entry.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lane_deskew_receiver.sv
// Multi-lane receive front end: hunts frame/line markers per lane, deskews lanes
// through per-lane FIFOs and emits one lane-aligned word bus with frame/line tags.
module lane_deskew_receiver
  import lane_rx_pkg::*;
#(
  parameter int                  NUM_LANES  = 4,
  parameter int                  DATA_W     = 6,
  parameter int                  FRAME_W    = 24,
  parameter logic [FRAME_W-1:0]  FRAME0     = FRAME0_DEFAULT,
  parameter logic [FRAME_W-1:0]  FRAME1     = FRAME1_DEFAULT,
  parameter int                  LINE_W     = 12,
  parameter logic [LINE_W-1:0]   LINE_MARK  = LINE_MARK_DEFAULT,
  parameter int                  SKEW_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES*DATA_W-1:0] lane_din,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic                        out_valid,
  output logic                        out_frame_start,
  output logic                        out_frame_odd,
  output logic                        out_line_start,
  output logic [NUM_LANES-1:0]        lane_locked,
  output logic                        aligned,
  output logic                        align_err
);

  localparam int BUS_W   = NUM_LANES * DATA_W;
  localparam int ENTRY_W = DATA_W + TAG_W;
  localparam int SKEW_W  = $clog2(SKEW_DEPTH);

  logic [BUS_W-1:0]           in_p0;
  logic [NUM_LANES-1:0]       frm_hit;
  logic [NUM_LANES-1:0]       odd_hit;
  logic [NUM_LANES-1:0]       line_hit;
  logic [NUM_LANES-1:0]       fifo_full;
  logic [NUM_LANES-1:0]       fifo_empty;
  logic [BUS_W-1:0]           rd_data;
  tag_t [NUM_LANES-1:0]       rd_tag;
  logic [1:0]                 state;
  logic [SKEW_W-1:0]          skew_cnt;
  logic                       rd_armed;
  logic                       pop;
  logic                       all_locked;
  logic                       timeout;
  logic                       fifo_fault;
  logic                       tag_mismatch;
  logic                       err_now;
  logic                       emit;

  // Stage p0: input register
  always_ff @(posedge clk) begin
    in_p0 <= lane_din;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_W-1:0]  word;
    logic [FRAME_W-1:0] hist;
    logic [FRAME_W-1:0] hist_next;
    tag_t               pend;
    logic [ENTRY_W-1:0] rd_entry;

    assign word        = in_p0[i*DATA_W +: DATA_W];
    assign hist_next   = FRAME_W'({hist, word});
    assign odd_hit[i]  = (hist_next == FRAME1);
    assign frm_hit[i]  = (hist_next == FRAME0) || odd_hit[i];
    assign line_hit[i] = (hist_next[LINE_W-1:0] == LINE_MARK);

    // The word now in in_p0 carries the hit found on the word before it.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist <= '0;
        pend <= '0;
      end else begin
        hist <= hist_next;
        pend <= {frm_hit[i], odd_hit[i], line_hit[i] && !frm_hit[i]};
      end
    end

    lane_deskew_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (SKEW_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (err_now),
      .wr_en   (lane_locked[i]),
      .wr_data ({word, pend}),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );

    assign rd_data[i*DATA_W +: DATA_W] = rd_entry[ENTRY_W-1:TAG_W];
    assign rd_tag[i]                   = rd_entry[TAG_W-1:0];
  end

  always_comb begin
    tag_mismatch = 1'b0;
    for (int i = 1; i < NUM_LANES; i++) begin
      if (rd_tag[i] != rd_tag[0]) tag_mismatch = 1'b1;
    end
  end

  // Reads begin one cycle after entering ALIGNED so the latest lane holds one entry.
  assign aligned    = (state == ST_ALIGNED);
  assign pop        = aligned && rd_armed;
  assign all_locked = &(lane_locked | frm_hit);
  assign timeout    = (state == ST_GATHER) && (skew_cnt == SKEW_W'(SKEW_DEPTH - 1));
  assign fifo_fault = (pop && |fifo_empty) || (!pop && |(fifo_full & lane_locked));
  assign err_now    = timeout || fifo_fault || (pop && tag_mismatch);
  assign emit       = pop && !err_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT;
      lane_locked <= '0;
      skew_cnt    <= '0;
      rd_armed    <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err <= err_now;
      if (err_now) begin
        state       <= ST_HUNT;
        lane_locked <= '0;
        rd_armed    <= 1'b0;
      end else begin
        case (state)
          ST_HUNT: begin
            if (|frm_hit) begin
              lane_locked <= frm_hit;
              skew_cnt    <= '0;
              state       <= (&frm_hit) ? ST_ALIGNED : ST_GATHER;
            end
          end
          ST_GATHER: begin
            lane_locked <= lane_locked | frm_hit;
            skew_cnt    <= skew_cnt + 1'b1;
            if (all_locked) state <= ST_ALIGNED;
          end
          ST_ALIGNED: rd_armed <= 1'b1;
          default:    state <= ST_HUNT;
        endcase
      end
    end
  end

  // Stage p1: registered read of the popped lane words
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_frame_start <= 1'b0;
      out_frame_odd   <= 1'b0;
      out_line_start  <= 1'b0;
    end else begin
      out_valid       <= emit;
      out_frame_start <= emit && rd_tag[0].frm;
      out_line_start  <= emit && rd_tag[0].line;
      if (emit) out_data <= rd_data;
      if (emit && rd_tag[0].frm) out_frame_odd <= rd_tag[0].odd;
    end
  end

endmodule

// File: tb/tb_lane_deskew_receiver.sv
// Directed-sequence bench with random payload: expected output is each lane's own
// word stream realigned at its first payload word, two edges after the latest lane.
module tb_lane_deskew_receiver;

  localparam int NL   = 4;
  localparam int DW   = 6;
  localparam int BW   = NL * DW;
  localparam int FWD  = 4;
  localparam int SKEW = 8;
  localparam int MAXT = 64;
  localparam logic [23:0] F0 = 24'hAA8D55;
  localparam logic [23:0] F1 = 24'hAAB155;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] lane_din;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_frame_start;
  logic          out_frame_odd;
  logic          out_line_start;
  logic [NL-1:0] lane_locked;
  logic          aligned;
  logic          align_err;

  lane_deskew_receiver dut (
    .clk             (clk),
    .rst             (rst),
    .lane_din        (lane_din),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_frame_start (out_frame_start),
    .out_frame_odd   (out_frame_odd),
    .out_line_start  (out_line_start),
    .lane_locked     (lane_locked),
    .aligned         (aligned),
    .align_err       (align_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] stim [NL][MAXT];
  logic          rst_stim [MAXT];
  logic [BW-1:0] cap_data [MAXT];
  logic          cap_valid [MAXT];
  logic          cap_fs [MAXT];
  logic          cap_fo [MAXT];
  logic          cap_ls [MAXT];
  logic [NL-1:0] cap_lock [MAXT];
  logic          cap_al [MAXT];
  logic          cap_err [MAXT];
  int            p_lane [NL];
  int            nvec = 0;
  int            nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random payload never uses 0x15, so markers appear only where placed.
  task automatic new_run(input int t_len);
    logic [DW-1:0] w;
    for (int t = 0; t < t_len; t++) begin
      rst_stim[t] = (t == 0);
      for (int i = 0; i < NL; i++) begin
        do w = DW'($urandom_range(0, 63)); while (w == 6'h15);
        stim[i][t] = w;
      end
    end
  endtask

  task automatic put_marker(input int lane, input int start, input logic [23:0] mk);
    for (int j = 0; j < FWD; j++) stim[lane][start + j] = mk[(FWD - 1 - j) * DW +: DW];
  endtask

  task automatic run(input int t_len);
    for (int t = 0; t < t_len; t++) begin
      rst = rst_stim[t];
      for (int i = 0; i < NL; i++) lane_din[i*DW +: DW] = stim[i][t];
      @(posedge clk);
      #1;
      cap_data[t]  = out_data;
      cap_valid[t] = out_valid;
      cap_fs[t]    = out_frame_start;
      cap_fo[t]    = out_frame_odd;
      cap_ls[t]    = out_line_start;
      cap_lock[t]  = lane_locked;
      cap_al[t]    = aligned;
      cap_err[t]   = align_err;
    end
  endtask

  task automatic check_reset(input int n);
    chk("rst_data", cap_data[n], 32'd0);
    chk("rst_valid", cap_valid[n], 32'd0);
    chk("rst_frame_start", cap_fs[n], 32'd0);
    chk("rst_frame_odd", cap_fo[n], 32'd0);
    chk("rst_line_start", cap_ls[n], 32'd0);
    chk("rst_locked", cap_lock[n], 32'd0);
    chk("rst_aligned", cap_al[n], 32'd0);
    chk("rst_err", cap_err[n], 32'd0);
  endtask

  task automatic expect_aligned(input int n0, input int n1, input logic odd, input int line_n);
    int late;
    int first;
    logic [BW-1:0] e;
    late = p_lane[0];
    for (int i = 1; i < NL; i++) if (p_lane[i] > late) late = p_lane[i];
    first = late + 2;
    for (int n = n0; n <= n1; n++) begin
      if (n < first) begin
        chk("pre_valid", cap_valid[n], 32'd0);
      end else begin
        for (int i = 0; i < NL; i++) e[i*DW +: DW] = stim[i][p_lane[i] + n - first];
        chk("data", cap_data[n], e);
        chk("valid", cap_valid[n], 32'd1);
        chk("frame_start", cap_fs[n], (n == first));
        chk("frame_odd", cap_fo[n], odd);
        chk("line_start", cap_ls[n], (n == line_n));
        chk("aligned", cap_al[n], 32'd1);
        chk("err", cap_err[n], 32'd0);
      end
    end
  endtask

  initial begin
    int tmo;
    rst      = 1'b1;
    lane_din = '0;

    // Zero skew, FRAME0, payload 01,02,03 then random
    new_run(24);
    for (int i = 0; i < NL; i++) begin
      put_marker(i, 2, F0);
      stim[i][6] = 6'h01;
      stim[i][7] = 6'h02;
      stim[i][8] = 6'h03;
      p_lane[i]  = 6;
    end
    run(24);
    check_reset(0);
    expect_aligned(1, 23, 1'b0, -1);
    chk("zs_word1", cap_data[8], {NL{6'h01}});
    chk("zs_word2", cap_data[9], {NL{6'h02}});
    chk("zs_word3", cap_data[10], {NL{6'h03}});
    chk("zs_locked", cap_lock[8], 32'hF);

    // Lane 2 delayed by 3 cycles, FRAME1
    new_run(24);
    for (int i = 0; i < NL; i++) begin
      put_marker(i, (i == 2) ? 5 : 2, F1);
      p_lane[i] = (i == 2) ? 9 : 6;
    end
    run(24);
    check_reset(0);
    expect_aligned(1, 23, 1'b1, -1);
    chk("sk3_locked", cap_lock[11], 32'hF);

    // Lane 3 delayed by SKEW_DEPTH cycles: window timeout
    new_run(24);
    for (int i = 0; i < NL; i++) put_marker(i, (i == 3) ? 2 + SKEW : 2, F0);
    run(24);
    check_reset(0);
    tmo = 2 + FWD + SKEW;
    for (int n = 1; n < 24; n++) begin
      chk("to_err", cap_err[n], (n == tmo));
      chk("to_valid", cap_valid[n], 32'd0);
      chk("to_aligned", cap_al[n], 32'd0);
    end
    chk("to_lock_before", cap_lock[2 + FWD - 1], 32'd0);
    chk("to_lock_first", cap_lock[2 + FWD], 32'h7);
    chk("to_lock_gather", cap_lock[tmo - 1], 32'h7);
    for (int n = tmo; n < 24; n++) chk("to_lock_clear", cap_lock[n], 32'd0);

    // Line marker, then lane-1-only line marker, then re-lock on FRAME0
    new_run(44);
    for (int i = 0; i < NL; i++) begin
      put_marker(i, 2, F0);
      stim[i][14] = 6'h15;
      stim[i][15] = 6'h15;
      stim[i][16] = 6'h3F;
      put_marker(i, 30, F0);
      p_lane[i] = 6;
    end
    stim[1][22] = 6'h15;
    stim[1][23] = 6'h15;
    run(44);
    check_reset(0);
    expect_aligned(1, 25, 1'b0, 18);
    chk("line_data", cap_data[18], {NL{6'h3F}});
    chk("mm_err", cap_err[26], 32'd1);
    chk("mm_valid", cap_valid[26], 32'd0);
    chk("mm_aligned", cap_al[26], 32'd0);
    chk("mm_err_single", cap_err[27], 32'd0);
    for (int i = 0; i < NL; i++) p_lane[i] = 34;
    expect_aligned(27, 43, 1'b0, -1);

    // Reset while aligned on FRAME1, then re-align on skewed FRAME0
    new_run(44);
    for (int i = 0; i < NL; i++) begin
      put_marker(i, 2, F1);
      put_marker(i, (i == 0) ? 22 : 20, F0);
      p_lane[i] = 6;
    end
    rst_stim[14] = 1'b1;
    run(44);
    check_reset(0);
    expect_aligned(1, 13, 1'b1, -1);
    check_reset(14);
    for (int i = 0; i < NL; i++) p_lane[i] = (i == 0) ? 26 : 24;
    expect_aligned(15, 43, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
